// File: rtl/ds18b20_scratchpad_decoder.sv
// ds18b20_scratchpad_decoder
//   Captures the 72-bit DS18B20 scratchpad when the 1-Wire controller finishes a
//   read, checks the Dallas CRC-8 bit-serially, and decodes the 12-bit
//   temperature into sign / BCD integer / BCD tenths for the display path.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a rising edge on i_convertion_done
//   CRC   | shifting frame bits 0..71 through the CRC-8, one per cycle
//   ABS   | magnitude/sign split, bus-error and CRC verdict registered
//   BCD   | 7-step double-dabble of the integer part
//   DONE  | o_valid strobe; result registers already hold the new frame
//
// Ports
//   i_clk, i_rst_n     clock, async active-low reset
//   i_convertion_done  read-complete level from the 1-Wire controller
//   i_ram_9byte        scratchpad, byte0 in [7:0], sampled on capture only
//   o_busy             capture cycle through the o_valid cycle
//   o_valid            one-cycle result strobe
//   o_crc_ok           last frame CRC good and no bus error
//   o_bus_error        last frame all-0 or all-1
//   o_por_value        last accepted temperature equals POR_RAW
//   o_temp_raw         last accepted raw temperature (1/16 C, 2's complement)
//   o_sign             1 = negative
//   o_bcd_int          |T| integer part, {hundreds,tens,units}
//   o_bcd_frac         tenths digit, truncated
module ds18b20_scratchpad_decoder #(
  parameter bit          CHECK_CRC = 1'b1,
  parameter logic [7:0]  CRC_POLY  = 8'h8C,
  parameter logic [15:0] POR_RAW   = 16'h0550
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_convertion_done,
  input  logic [71:0] i_ram_9byte,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_crc_ok,
  output logic        o_bus_error,
  output logic        o_por_value,
  output logic [15:0] o_temp_raw,
  output logic        o_sign,
  output logic [11:0] o_bcd_int,
  output logic [3:0]  o_bcd_frac
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC,
    ST_ABS,
    ST_BCD,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        done_q;
  logic        start;
  logic [71:0] frame_q;
  logic [6:0]  bit_cnt_q;
  logic [2:0]  bcd_cnt_q;
  logic [7:0]  crc_q;
  logic [7:0]  crc_next;
  logic        crc_fb;
  logic [10:0] mag;
  logic [3:0]  frac_q;
  logic        bus_err_q;
  logic        crc_ok_q;
  logic [18:0] dd_q;
  logic [18:0] dd_adj;
  logic [18:0] dd_step;
  logic [3:0]  frac_digit;
  logic        bus_err;

  // Gated by reset so o_busy reads 0 while reset is held, even with the
  // done level already high and the edge flop cleared.
  assign start   = i_rst_n & (state_q == ST_IDLE) & i_convertion_done & ~done_q;
  assign o_busy  = start | (state_q != ST_IDLE);
  assign o_valid = (state_q == ST_DONE);

  assign crc_fb   = crc_q[0] ^ frame_q[bit_cnt_q];
  assign crc_next = (crc_q >> 1) ^ (crc_fb ? CRC_POLY : 8'h00);

  // Only mag[10:4] and mag[3:0] are ever used, so the 16-bit negate is
  // carried out on the low 11 bits alone (identical result for those bits).
  assign mag     = frame_q[15] ? (~frame_q[10:0] + 11'd1) : frame_q[10:0];
  assign bus_err = (frame_q == 72'h0) | (frame_q == {72{1'b1}});

  assign frac_digit = 4'(({4'b0000, frac_q} * 8'd10) >> 4);

  // Double-dabble step: dd = {hundreds, tens, units, binary[6:0]}.
  always_comb begin
    dd_adj = dd_q;
    if (dd_adj[10:7]  >= 4'd5) dd_adj[10:7]  = dd_adj[10:7]  + 4'd3;
    if (dd_adj[14:11] >= 4'd5) dd_adj[14:11] = dd_adj[14:11] + 4'd3;
    if (dd_adj[18:15] >= 4'd5) dd_adj[18:15] = dd_adj[18:15] + 4'd3;
    dd_step = {dd_adj[17:0], 1'b0};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CRC;
      ST_CRC:  if (bit_cnt_q == 7'd71) state_d = ST_ABS;
      ST_ABS:  state_d = ST_BCD;
      ST_BCD:  if (bcd_cnt_q == 3'd6) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_q      <= 1'b0;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      bcd_cnt_q   <= '0;
      crc_q       <= '0;
      frac_q      <= '0;
      bus_err_q   <= 1'b0;
      crc_ok_q    <= 1'b0;
      dd_q        <= '0;
      o_crc_ok    <= 1'b0;
      o_bus_error <= 1'b0;
      o_por_value <= 1'b0;
      o_temp_raw  <= '0;
      o_sign      <= 1'b0;
      o_bcd_int   <= '0;
      o_bcd_frac  <= '0;
    end else begin
      done_q <= i_convertion_done;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            frame_q   <= i_ram_9byte;
            crc_q     <= 8'h00;
            bit_cnt_q <= 7'd0;
          end
        end
        ST_CRC: begin
          crc_q     <= crc_next;
          bit_cnt_q <= bit_cnt_q + 7'd1;
        end
        ST_ABS: begin
          frac_q    <= mag[3:0];
          bus_err_q <= bus_err;
          crc_ok_q  <= (crc_q == 8'h00) & ~bus_err;
          dd_q      <= {12'h000, mag[10:4]};
          bcd_cnt_q <= 3'd0;
        end
        ST_BCD: begin
          dd_q      <= dd_step;
          bcd_cnt_q <= bcd_cnt_q + 3'd1;
          // Results land on the edge into DONE so they are current with o_valid.
          if (bcd_cnt_q == 3'd6) begin
            o_crc_ok    <= crc_ok_q;
            o_bus_error <= bus_err_q;
            if (crc_ok_q || !CHECK_CRC) begin
              o_temp_raw  <= frame_q[15:0];
              o_sign      <= frame_q[15];
              o_bcd_int   <= dd_step[18:7];
              o_bcd_frac  <= frac_digit;
              o_por_value <= (frame_q[15:0] == POR_RAW);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ds18b20_scratchpad_decoder.sv
// Directed bench for ds18b20_scratchpad_decoder. Two instances share the
// stimulus: dut (CRC gates updates) and dut_nc (CRC reported only).
module tb_ds18b20_scratchpad_decoder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_convertion_done = 1'b0;
  logic [71:0] i_ram_9byte = '0;

  logic        busy, valid, crc_ok, bus_error, por_value, sign;
  logic [15:0] temp_raw;
  logic [11:0] bcd_int;
  logic [3:0]  bcd_frac;

  logic        nc_busy, nc_valid, nc_crc_ok, nc_bus_error, nc_por_value, nc_sign;
  logic [15:0] nc_temp_raw;
  logic [11:0] nc_bcd_int;
  logic [3:0]  nc_bcd_frac;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  ds18b20_scratchpad_decoder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_convertion_done(i_convertion_done),
    .i_ram_9byte(i_ram_9byte), .o_busy(busy), .o_valid(valid), .o_crc_ok(crc_ok),
    .o_bus_error(bus_error), .o_por_value(por_value), .o_temp_raw(temp_raw),
    .o_sign(sign), .o_bcd_int(bcd_int), .o_bcd_frac(bcd_frac)
  );

  ds18b20_scratchpad_decoder #(.CHECK_CRC(1'b0)) dut_nc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_convertion_done(i_convertion_done),
    .i_ram_9byte(i_ram_9byte), .o_busy(nc_busy), .o_valid(nc_valid), .o_crc_ok(nc_crc_ok),
    .o_bus_error(nc_bus_error), .o_por_value(nc_por_value), .o_temp_raw(nc_temp_raw),
    .o_sign(nc_sign), .o_bcd_int(nc_bcd_int), .o_bcd_frac(nc_bcd_frac)
  );

  always #10 i_clk = ~i_clk;

  always @(negedge i_clk) if (valid) n_valid++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_main(input string t, input logic ok, input logic be, input logic por,
                            input logic [15:0] raw, input logic sg, input logic [11:0] bi,
                            input logic [3:0] bf);
    check_eq({t, "_crc_ok"},    32'(crc_ok),    32'(ok));
    check_eq({t, "_bus_error"}, 32'(bus_error), 32'(be));
    check_eq({t, "_por"},       32'(por_value), 32'(por));
    check_eq({t, "_raw"},       32'(temp_raw),  32'(raw));
    check_eq({t, "_sign"},      32'(sign),      32'(sg));
    check_eq({t, "_bcd_int"},   32'(bcd_int),   32'(bi));
    check_eq({t, "_bcd_frac"},  32'(bcd_frac),  32'(bf));
  endtask

  task automatic check_nc(input string t, input logic ok, input logic be, input logic por,
                          input logic [15:0] raw, input logic sg, input logic [11:0] bi,
                          input logic [3:0] bf);
    check_eq({t, "_nc_valid"},     32'(nc_valid),     32'd1);
    check_eq({t, "_nc_crc_ok"},    32'(nc_crc_ok),    32'(ok));
    check_eq({t, "_nc_bus_error"}, 32'(nc_bus_error), 32'(be));
    check_eq({t, "_nc_por"},       32'(nc_por_value), 32'(por));
    check_eq({t, "_nc_raw"},       32'(nc_temp_raw),  32'(raw));
    check_eq({t, "_nc_sign"},      32'(nc_sign),      32'(sg));
    check_eq({t, "_nc_bcd_int"},   32'(nc_bcd_int),   32'(bi));
    check_eq({t, "_nc_bcd_frac"},  32'(nc_bcd_frac),  32'(bf));
  endtask

  function automatic logic [7:0] crc8_model(input logic [63:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [71:0] mk_frame(input logic [15:0] raw, input logic [7:0] b8);
    return {b8, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, raw};
  endfunction

  // Raises done one cycle (T), then waits for o_valid; lat = cycles after T.
  task automatic run_frame(input string t, input logic [71:0] f, output int lat);
    lat = -1;
    @(posedge i_clk); #1;
    i_ram_9byte = f;
    i_convertion_done = 1'b1;
    #1 check_eq({t, "_busy_T"}, 32'(busy), 32'd1);
    for (int c = 1; c <= 120 && lat < 0; c++) begin
      @(posedge i_clk); #1;
      if (valid) lat = c;
    end
    check_eq({t, "_latency"}, lat, 32'd81);
    check_eq({t, "_busy_valid"}, 32'(busy), 32'd1);
  endtask

  task automatic end_frame(input string t);
    @(posedge i_clk); #1;
    i_convertion_done = 1'b0;
    check_eq({t, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  logic [71:0] f1, f2, f3, f6;
  int lat;
  int v0;

  initial begin
    f1 = mk_frame(16'h0550, 8'h1C);
    f2 = mk_frame(16'hFF5E, 8'h00);
    f2[71:64] = crc8_model(f2[63:0]);
    f3 = f2;
    f3[64] = ~f3[64];
    f6 = mk_frame(16'h0191, 8'h00);
    f6[71:64] = crc8_model(f6[63:0]);

    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_valid",  32'(valid),    32'd0);
    check_eq("rst_busy",   32'(busy),     32'd0);
    check_eq("rst_crc_ok", 32'(crc_ok),   32'd0);
    check_eq("rst_raw",    32'(temp_raw), 32'd0);
    check_eq("rst_bcd",    32'(bcd_int),  32'd0);
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);

    // POR frame from the datasheet, +85.0 C
    run_frame("t1", f1, lat);
    check_main("t1", 1'b1, 1'b0, 1'b1, 16'h0550, 1'b0, 12'h085, 4'd0);
    check_nc("t1", 1'b1, 1'b0, 1'b1, 16'h0550, 1'b0, 12'h085, 4'd0);
    end_frame("t1");

    // -10.125 C with corrupted CRC: dut holds, dut_nc updates
    run_frame("t3", f3, lat);
    check_main("t3", 1'b0, 1'b0, 1'b1, 16'h0550, 1'b0, 12'h085, 4'd0);
    check_nc("t3", 1'b0, 1'b0, 1'b0, 16'hFF5E, 1'b1, 12'h010, 4'd1);
    end_frame("t3");

    // -10.125 C, good CRC
    run_frame("t2", f2, lat);
    check_main("t2", 1'b1, 1'b0, 1'b0, 16'hFF5E, 1'b1, 12'h010, 4'd1);
    end_frame("t2");

    // Bus errors; all-zero passes CRC but must still be rejected
    run_frame("t4z", 72'h0, lat);
    check_main("t4z", 1'b0, 1'b1, 1'b0, 16'hFF5E, 1'b1, 12'h010, 4'd1);
    check_nc("t4z", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 12'h000, 4'd0);
    end_frame("t4z");
    run_frame("t4f", {72{1'b1}}, lat);
    check_main("t4f", 1'b0, 1'b1, 1'b0, 16'hFF5E, 1'b1, 12'h010, 4'd1);
    check_nc("t4f", 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 12'h000, 4'd0);
    end_frame("t4f");

    // Extra edge while busy, then level held high: one result only
    v0 = n_valid;
    @(posedge i_clk); #1;
    i_ram_9byte = f2;
    i_convertion_done = 1'b1;
    repeat (38) @(posedge i_clk);
    #1 i_convertion_done = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_convertion_done = 1'b1;
    repeat (200) @(posedge i_clk);
    #1;
    check_eq("t5_valid_count", n_valid - v0, 32'd1);
    check_eq("t5_busy_held", 32'(busy), 32'd0);
    i_convertion_done = 1'b0;
    run_frame("t5", f1, lat);
    check_main("t5", 1'b1, 1'b0, 1'b1, 16'h0550, 1'b0, 12'h085, 4'd0);
    end_frame("t5");

    // Reset mid-frame
    @(posedge i_clk); #1;
    i_ram_9byte = f2;
    i_convertion_done = 1'b1;
    repeat (50) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    v0 = n_valid;
    #1;
    check_eq("t6_rst_busy",   32'(busy),      32'd0);
    check_eq("t6_rst_valid",  32'(valid),     32'd0);
    check_eq("t6_rst_crc_ok", 32'(crc_ok),    32'd0);
    check_eq("t6_rst_por",    32'(por_value), 32'd0);
    check_eq("t6_rst_raw",    32'(temp_raw),  32'd0);
    check_eq("t6_rst_bcd",    32'(bcd_int),   32'd0);
    i_convertion_done = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (100) @(posedge i_clk);
    #1 check_eq("t6_no_valid", n_valid - v0, 32'd0);
    run_frame("t6", f6, lat);
    check_main("t6", 1'b1, 1'b0, 1'b0, 16'h0191, 1'b0, 12'h025, 4'd0);
    end_frame("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
